// File: rtl/i2c_pkg.sv
// Shared widths, direction constants and slave FSM state encoding for the I2C blocks.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StWaitStop
  } i2c_slv_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// scl/sda synchronizers, optional stability filter (I2C_SLAVE_GLITCH_FILTER_EN) and
// bus event detection (scl edges, START, STOP).
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  if (FILTER_LEN < 1) begin : gen_filter_len_check
    $error("FILTER_LEN must be at least 1");
  end

  // Bit 0 carries scl, bit 1 carries sda; both idle high.
  logic [1:0] sync1_q, sync2_q, line, prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {sda, scl};
      sync2_q <= sync1_q;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic [1:0]           filt_q;
  logic [1:0][CntW-1:0] cnt_q;

  // A line flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 2'b11;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign line = filt_q;
`else
  assign line = sync2_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 2'b11;
    end else begin
      prev_q <= line;
    end
  end

  assign scl_rise  = line[0] & ~prev_q[0];
  assign scl_fall  = ~line[0] & prev_q[0];
  assign start_det = line[0] & prev_q[0] & prev_q[1] & ~line[1];
  assign stop_det  = line[0] & prev_q[0] & ~prev_q[1] & line[1];
  assign sda_s     = line[1];

endmodule

// File: rtl/i2c_slave.sv
// 7-bit-address I2C slave: ACKs SLAVE_ADDR, hands write bytes to user logic and fetches
// read bytes on demand. Define I2C_SLAVE_GLITCH_FILTER_EN to enable the scl/sda filter.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h36,
  parameter int unsigned           FILTER_LEN = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  inout  wire                   sda,
  output logic                  busy,
  output logic                  wr_valid,
  output logic [I2C_DATA_W-1:0] wr_data,
  output logic                  rd_req,
  input  logic [I2C_DATA_W-1:0] rd_data,
  output logic                  ack_error
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_bus_sync (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  i2c_slv_state_t        state_q;
  logic [3:0]            bit_cnt_q;
  logic [I2C_DATA_W-1:0] rx_q, tx_q, wr_data_q, rx_next, tx_shift;
  logic                  rw_q, ack_on_q, sda_oe_q;
  logic                  busy_q, wr_valid_q, rd_req_q, rd_load_q, ack_error_q;

  assign rx_next  = {rx_q[I2C_DATA_W-2:0], sda_s};
  assign tx_shift = {tx_q[I2C_DATA_W-2:0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '1;
      wr_data_q   <= '0;
      rw_q        <= I2C_WRITE;
      ack_on_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_load_q   <= 1'b0;
      ack_error_q <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      // User logic gets one full cycle after rd_req before rd_data is captured.
      rd_load_q  <= rd_req_q;
      if (rd_load_q) tx_q <= rd_data;

      if (start_det || stop_det) begin
        if (state_q == StRdData) ack_error_q <= 1'b1;
        busy_q    <= 1'b0;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= '0;
        ack_on_q  <= 1'b0;
        state_q   <= start_det ? StAddr : StIdle;
      end else begin
        unique case (state_q)
          StAddr: begin
            if (scl_rise) begin
              rx_q      <= rx_next;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (rx_next[I2C_DATA_W-1:1] == SLAVE_ADDR) begin
                  busy_q      <= 1'b1;
                  ack_error_q <= 1'b0;
                  rw_q        <= rx_next[0];
                  ack_on_q    <= 1'b0;
                  state_q     <= StAddrAck;
                  if (rx_next[0] == I2C_READ) rd_req_q <= 1'b1;
                end else begin
                  state_q <= StWaitStop;
                end
              end
            end
          end

          // First fall starts the ACK pulse, the second one ends it.
          StAddrAck, StWrAck: begin
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                ack_on_q  <= 1'b0;
                bit_cnt_q <= '0;
                if (state_q == StWrAck || rw_q == I2C_WRITE) begin
                  sda_oe_q <= 1'b0;
                  state_q  <= StWrData;
                end else begin
                  sda_oe_q  <= ~tx_q[I2C_DATA_W-1];
                  tx_q      <= tx_shift;
                  bit_cnt_q <= 4'd1;
                  state_q   <= StRdData;
                end
              end
            end
          end

          StWrData: begin
            if (scl_rise) begin
              rx_q      <= rx_next;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                wr_data_q  <= rx_next;
                wr_valid_q <= 1'b1;
                ack_on_q   <= 1'b0;
                state_q    <= StWrAck;
              end
            end
          end

          // bit_cnt counts bits already placed on the bus for this byte.
          StRdData: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                ack_on_q <= 1'b0;
                state_q  <= StRdAck;
              end else begin
                sda_oe_q  <= ~tx_q[I2C_DATA_W-1];
                tx_q      <= tx_shift;
                bit_cnt_q <= bit_cnt_q + 4'd1;
              end
            end
          end

          StRdAck: begin
            if (scl_rise) begin
              if (!sda_s) begin
                rd_req_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                state_q <= StWaitStop;
              end
            end else if (scl_fall && ack_on_q) begin
              ack_on_q  <= 1'b0;
              sda_oe_q  <= ~tx_q[I2C_DATA_W-1];
              tx_q      <= tx_shift;
              bit_cnt_q <= 4'd1;
              state_q   <= StRdData;
            end
          end

          default: begin
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign wr_valid  = wr_valid_q;
  assign wr_data   = wr_data_q;
  assign rd_req    = rd_req_q;
  assign ack_error = ack_error_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, directed cases plus random transactions
// checked against a transaction-level expectation model.
module tb_i2c_slave;

  localparam int unsigned Q       = 8;   // clk cycles per quarter SCL period
  localparam logic [6:0]  OwnAddr = 7'h36;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       scl      = 1'b1;
  logic       m_sda_oe = 1'b0;
  logic [7:0] rd_data;
  logic       busy, wr_valid, rd_req, ack_error;
  logic [7:0] wr_data;

  wire sda;
  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  int         n_checks   = 0;
  int         n_fail     = 0;
  int         rd_req_cnt = 0;
  logic [7:0] wr_seen[$];
  logic [7:0] rd_src[$];

  i2c_slave dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .ack_error(ack_error)
  );

  always #5 clk = ~clk;

  // User-side model: record write bytes, answer read requests from rd_src.
  always @(negedge clk) begin
    if (wr_valid) wr_seen.push_back(wr_data);
    if (rd_req) begin
      rd_req_cnt++;
      rd_data = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // Works from idle and as a repeated START from scl low.
  task automatic m_start();
    m_sda_oe = 1'b0; wait_q();
    scl = 1'b1;      wait_q();
    m_sda_oe = 1'b1; wait_q();
    scl = 1'b0;      wait_q();
  endtask

  task automatic m_stop();
    m_sda_oe = 1'b1; wait_q();
    scl = 1'b1;      wait_q();
    m_sda_oe = 1'b0; wait_q();
  endtask

  task automatic m_bit(input logic b, output logic s);
    m_sda_oe = ~b; wait_q();
    scl = 1'b1;    wait_q();
    s = sda;       wait_q();
    scl = 1'b0;    wait_q();
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(d[i], s);
    m_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic m_read_byte(input logic send_ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_bit(1'b1, s);
      d = {d[6:0], s};
    end
    m_bit(~send_ack, s);
  endtask

  // One complete transaction; expectations come from the address/direction rules only.
  task automatic run_txn(input logic [6:0] addr, input logic rw, input int len,
                         input logic [7:0] first);
    logic       ack, hit;
    logic [7:0] got;
    logic [7:0] exp_q[$];
    int         rq0;
    hit = (addr == OwnAddr);
    wr_seen.delete();
    rq0 = rd_req_cnt;
    for (int i = 0; i < len; i++) exp_q.push_back((i == 0) ? first : 8'($urandom));
    if (rw) rd_src = exp_q;
    m_start();
    m_write_byte({addr, rw}, ack);
    check("addr_ack", ack, hit);
    check("busy_after_addr", busy, hit);
    if (hit) begin
      for (int i = 0; i < len; i++) begin
        if (!rw) begin
          m_write_byte(exp_q[i], ack);
          check("wr_ack", ack, 1);
        end else begin
          m_read_byte(i != len - 1, got);
          check("rd_byte", got, exp_q[i]);
        end
      end
    end
    m_stop();
    check("busy_after_stop", busy, 0);
    check("wr_count", wr_seen.size(), (hit && !rw) ? len : 0);
    if (hit && !rw) begin
      for (int i = 0; i < len && i < wr_seen.size(); i++) check("wr_byte", wr_seen[i], exp_q[i]);
    end
    check("rd_req_count", rd_req_cnt - rq0, (hit && rw) ? len : 0);
    check("ack_error", ack_error, 0);
    rd_src.delete();
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] got, abyte;
    int         n_ack;

    repeat (4) @(negedge clk);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_ack_error", ack_error, 0);
    check("rst_wr_data", wr_data, 8'h00);
    reset = 1'b1;
    wait_q();

    run_txn(OwnAddr, 1'b0, 1, 8'hA5);
    run_txn(7'h35, 1'b0, 1, 8'h00);
    run_txn(OwnAddr, 1'b1, 1, 8'h1A);

    // Multi-byte write
    wr_seen.delete();
    n_ack = 0;
    m_start();
    m_write_byte({OwnAddr, 1'b0}, ack); n_ack += int'(ack);
    m_write_byte(8'h01, ack);           n_ack += int'(ack);
    m_write_byte(8'hFF, ack);           n_ack += int'(ack);
    m_stop();
    check("mb_acks", n_ack, 3);
    check("mb_count", wr_seen.size(), 2);
    check("mb_byte0", (wr_seen.size() > 0) ? wr_seen[0] : 8'h00, 8'h01);
    check("mb_byte1", (wr_seen.size() > 1) ? wr_seen[1] : 8'h00, 8'hFF);

    // Repeated START after 4 data bits
    wr_seen.delete();
    m_start();
    m_write_byte({OwnAddr, 1'b0}, ack);
    check("rs_addr_ack", ack, 1);
    for (int i = 0; i < 4; i++) m_bit(i[0], s);
    m_start();
    check("rs_busy_dropped", busy, 0);
    m_write_byte({OwnAddr, 1'b0}, ack);
    check("rs_readdr_ack", ack, 1);
    m_write_byte(8'h5C, ack);
    m_stop();
    check("rs_count", wr_seen.size(), 1);
    check("rs_byte", (wr_seen.size() > 0) ? wr_seen[0] : 8'h00, 8'h5C);

    // Read truncated by STOP mid-byte (all-ones data keeps sda free for the master)
    rd_src.push_back(8'hFF);
    m_start();
    m_write_byte({OwnAddr, 1'b1}, ack);
    check("tr_addr_ack", ack, 1);
    for (int i = 0; i < 3; i++) m_bit(1'b1, s);
    m_stop();
    check("tr_ack_error", ack_error, 1);
    check("tr_busy", busy, 0);
    rd_src.delete();
    run_txn(OwnAddr, 1'b0, 1, 8'h3C);

    // Reset while the slave holds the address ACK
    abyte = {OwnAddr, 1'b0};
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(abyte[i], s);
    m_sda_oe = 1'b0;
    repeat (2) @(negedge clk);
    check("ra_ack_driven", sda, 0);
    check("ra_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("ra_sda_released", sda, 1);
    check("ra_busy_rst", busy, 0);
    check("ra_wr_valid_rst", wr_valid, 0);
    check("ra_rd_req_rst", rd_req, 0);
    check("ra_ack_error_rst", ack_error, 0);
    check("ra_wr_data_rst", wr_data, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    wait_q();
    m_stop();
    wait_q();

    for (int t = 0; t < 12; t++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 1) == 1) ? OwnAddr : 7'($urandom);
      run_txn(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
